// File: rtl/bin2gray_wptr.sv
// bin2gray_wptr
// Producer-side pointer generator for a dual-clock buffer. It keeps a binary
// write pointer and exports it as a registered Gray pointer. It brings the
// consumer's Gray read pointer in through a two-flop synchroniser, decodes it,
// and derives full, level and almost-full from it.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset
//   push         producer write request
//   rd_gray      Gray read pointer from the consumer clock domain
//   accept       push && !full (combinational); the write is taken this cycle
//   waddr        storage address (binary write pointer without the wrap bit)
//   wr_gray      registered Gray write pointer for export
//   full         registered full flag
//   almost_full  registered, level >= AFULL_THRESH
//   level        registered occupancy, 0..2^(WIDTH-1)
module bin2gray_wptr #(
   parameter int unsigned WIDTH        = 8,
   parameter int unsigned AFULL_THRESH = 120
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] rd_gray,
   output logic             accept,
   output logic [WIDTH-2:0] waddr,
   output logic [WIDTH-1:0] wr_gray,
   output logic             full,
   output logic             almost_full,
   output logic [WIDTH-1:0] level
);

   localparam logic [WIDTH-1:0] AF_LIM = WIDTH'(AFULL_THRESH);

   logic [WIDTH-1:0] wr_bin;
   logic [WIDTH-1:0] rs1, rs2;
   logic [WIDTH-1:0] nb, nb_gray, rb, diff, full_cmp;

   assign accept = push && !full;
   assign waddr  = wr_bin[WIDTH-2:0];

   always_comb begin
      nb      = wr_bin + {{(WIDTH-1){1'b0}}, accept};
      nb_gray = nb ^ (nb >> 1);
      // Each binary bit is the XOR of all Gray bits at or above it.
      rb = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         rb[i] = ^(rs2 >> i);
      end
      diff     = nb - rb;
      // The write pointer is exactly one lap ahead when the top two Gray bits
      // differ from the read pointer's and the rest match.
      full_cmp = {~rs2[WIDTH-1], ~rs2[WIDTH-2], rs2[WIDTH-3:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_bin      <= '0;
         wr_gray     <= '0;
         rs1         <= '0;
         rs2         <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
         level       <= '0;
      end else begin
         rs1         <= rd_gray;
         rs2         <= rs1;
         wr_bin      <= nb;
         wr_gray     <= nb_gray;
         full        <= (nb_gray == full_cmp);
         almost_full <= (diff >= AF_LIM);
         level       <= diff;
      end
   end

endmodule

// File: doc/bin2gray_wptr.md
# bin2gray_wptr

Write-side pointer generator for a Gray-coded pointer interface: the encoder end of our Gray-to-binary path. It maintains a binary write pointer, publishes it as a registered (glitch-free) Gray pointer for the consumer domain, and resynchronises the consumer's Gray read pointer through two flops. It also decodes that read pointer to produce full, occupancy level and almost-full flags. It sits on the producer side of a dual-clock buffer, alongside the storage RAM (driven by `waddr`).

## Interface
- `WIDTH`, default 8: pointer width including the wrap bit. Buffer depth is 2^(WIDTH-1). Legal range is WIDTH ≥ 3.
- `AFULL_THRESH`, default 120: `almost_full` asserts when `level` ≥ this value. Legal range is 1..2^(WIDTH-1).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `push`  in  1  producer write request.
- `rd_gray`  in  WIDTH  Gray read pointer from the consumer domain; asynchronous to `clk`.
- `accept`  out  1  combinational, equal to `push && !full`; the write is taken this cycle.
- `waddr`  out  WIDTH-1  storage address, equal to the binary write pointer without its MSB.
- `wr_gray`  out  WIDTH  registered Gray write pointer for export.
- `full`  out  1  registered.
- `almost_full`  out  1  registered.
- `level`  out  WIDTH  registered occupancy, range 0..2^(WIDTH-1).

## Operation
- State:
  - `wr_bin[WIDTH]`: binary write pointer.
  - `wr_gray` register.
  - `rs1`, `rs2`: two-flop synchroniser on `rd_gray`.
  - `full`, `almost_full`, `level` registers.
- Reset (`rst`=1 at an edge) forces all of the above to 0. `rst` has priority over `push`.
- Each edge:
  - `rs1 <= rd_gray`, then `rs2 <= rs1`.
- Next write pointer:
  - `nb = wr_bin + accept`, taken mod 2^WIDTH, so 2^WIDTH-1 wraps to 0.
  - `wr_bin <= nb`.
  - `wr_gray <= nb ^ (nb >> 1)`. `wr_gray` is always taken straight from a register; there is no combinational path to the output.
- Read pointer decode:
  - `rb = gray2bin(rs2)`, where `rb[WIDTH-1] = rs2[WIDTH-1]` and `rb[i] = rb[i+1] ^ rs2[i]`.
- Flags:
  - `level <= (nb - rb)` mod 2^WIDTH.
  - `full <= (nb ^ (nb>>1)) == {~rs2[W-1], ~rs2[W-2], rs2[W-3:0]}`. This is equivalent to `level` = 2^(WIDTH-1).
  - `almost_full <= (nb - rb) mod 2^WIDTH >= AFULL_THRESH`.
- Flags are pessimistic by design: a push updates them at the same edge, but read progress appears only after synchronisation.
- Push while `full`: `accept`=0, pointer unchanged, no error state.
- `rd_gray` is trusted to change by at most one bit per consumer clock. No checking is performed on it.

## Timing
- `accept` has zero latency. It is combinational from `push` and the registered `full`.
- Accepted push at edge k: `waddr`, `wr_gray`, `level`, `full` and `almost_full` all reflect it immediately after edge k.
- `rd_gray` change sampled at edge k: it reaches `rs1` at k and `rs2` at k+1, and is reflected in `level`/`full`/`almost_full` after edge k+2. That is 3 edges total.
- `wr_gray` changes by exactly one bit per accepted push, including at wrap-around. It is constant when nothing is accepted.
- Reset mid-operation: outputs are 0 after the reset edge and `push` is ignored on that edge. `accept` still follows `push && !full` combinationally; `full` is 0 during reset.

## Test plan
(WIDTH=8, AFULL_THRESH=120, rd_gray held at 0 unless stated.)
1. Reset: hold `rst` for 2 edges → `waddr`=0, `wr_gray`=0x00, `level`=0, `full`=0, `almost_full`=0.
2. Push 5 consecutive cycles → `waddr`=5, `wr_gray`=0x07, `level`=5, `accept`=1 each cycle. The Gray sequence is 01,03,02,06,07, with a one-bit change per step.
3. Push 128 cycles → `almost_full` rises after the 120th edge and `full` rises after the 128th, with `wr_gray`=0xC0 and `level`=128. A 129th push gives `accept`=0 with all outputs unchanged.
4. From the full state, drive `rd_gray`=0x01 → `full`=0 and `level`=127 exactly 3 edges later, with no change before that. A push is then accepted, giving `wr_gray`=0xC1 and `full`=1 again.
5. Wrap: with `rd_gray`=0x80 (bin 0xFF) and `wr_bin` at 0xFF, push once → `wr_bin`=0x00, `wr_gray`=0x00, `level`=1, a single-bit change on `wr_gray`.
6. Reset mid-run: at `level`=50, assert `rst` with `push`=1 → all outputs 0 after the edge. `rst` is then released, and the next push gives `waddr`=1 and `wr_gray`=0x01.
